rc4_ksa_engine: RTL and testbench

Parametrised RC4 key-scheduling engine: optionally initialises the state array S to the identity permutation, then runs the full KSA swap loop over S using a runtime-selectable key length. It sits between the key source (switches/cracking controller) and a single-port synchronous S RAM. A start/busy/done handshake lets a controller rerun it with new keys without resetting.

---
 rtl/rc4_pkg.sv | 21 ++
 rtl/rc4_ksa_engine_wrap_counter.sv | 37 +++
 rtl/rc4_ksa_engine.sv | 203 ++++++++++++++++++++
 tb/tb_rc4_ksa_engine.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared types and defaults for the RC4 key-scheduling engine.
package rc4_pkg;

  localparam int unsigned DEPTH_LOG2_DEF    = 8;
  localparam int unsigned MAX_KEY_BYTES_DEF = 16;
  localparam int unsigned KEY_BYTE_W        = 8;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INIT_WR = 4'd1,
    ST_RD_SI   = 4'd2,
    ST_CAP_SI  = 4'd3,
    ST_RD_SJ   = 4'd4,
    ST_CAP_SJ  = 4'd5,
    ST_WR_SJ   = 4'd6,
    ST_WR_SI   = 4'd7,
    ST_NEXT    = 4'd8,
    ST_DONE    = 4'd9
  } ksa_state_e;

endpackage

// File: rtl/rc4_ksa_engine_wrap_counter.sv
// Up-counter that returns to zero after reaching a runtime limit.
module wrap_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] wrap_val,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over increment; increment wraps at wrap_val.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = (count_q == wrap_val) ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving a single-port synchronous S RAM.
// Optional identity fill of S, then 2**DEPTH_LOG2 swap iterations of
// 7 cycles each (read S[i], read S[j], write S[j], write S[i]).
module rc4_ksa_engine
  import rc4_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2    = DEPTH_LOG2_DEF,
  parameter int unsigned MAX_KEY_BYTES = MAX_KEY_BYTES_DEF,
  parameter int unsigned KEY_LEN_W     = $clog2(MAX_KEY_BYTES + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                init_en,
  input  logic [KEY_LEN_W-1:0]                key_len,
  input  logic [KEY_BYTE_W*MAX_KEY_BYTES-1:0] key,
  input  logic [DEPTH_LOG2-1:0]               mem_rdata,
  output logic [DEPTH_LOG2-1:0]               mem_addr,
  output logic [DEPTH_LOG2-1:0]               mem_wdata,
  output logic                                mem_wren,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);

  localparam logic [DEPTH_LOG2-1:0] IDX_MAX = '1;

  ksa_state_e state_q, state_d;

  logic [DEPTH_LOG2-1:0] i_q, i_d;
  logic [DEPTH_LOG2-1:0] j_q, j_d;
  logic [DEPTH_LOG2-1:0] si_q, si_d;
  logic [DEPTH_LOG2-1:0] sj_q, sj_d;
  logic [KEY_LEN_W-1:0]  key_len_q, key_len_d;

  logic [DEPTH_LOG2-1:0] mem_addr_q, mem_addr_d;
  logic [DEPTH_LOG2-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_wren_q, mem_wren_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  k_clr;
  logic                  k_en;
  logic [KEY_LEN_W-1:0]  k;
  logic [KEY_LEN_W-1:0]  k_wrap;
  logic [KEY_BYTE_W-1:0] key_byte;
  logic [DEPTH_LOG2-1:0] key_byte_n;
  logic                  key_len_ok;

  // Key index k walks 0..key_len-1 once per swap iteration.
  assign k_wrap = key_len_q - KEY_LEN_W'(1);

  wrap_counter #(
    .WIDTH (KEY_LEN_W)
  ) u_k_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (k_clr),
    .en       (k_en),
    .wrap_val (k_wrap),
    .count    (k)
  );

  // Key byte mux indexed by k, truncated/extended to the S entry width.
  always_comb begin
    key_byte = '0;
    for (int unsigned b = 0; b < MAX_KEY_BYTES; b++) begin
      if (k == KEY_LEN_W'(b)) begin
        key_byte = key[KEY_BYTE_W*b +: KEY_BYTE_W];
      end
    end
  end

  assign key_byte_n = DEPTH_LOG2'(key_byte);
  assign key_len_ok = (key_len != '0) && (key_len <= KEY_LEN_W'(MAX_KEY_BYTES));

  // Next-state logic plus registered output decode from the next state.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    si_d        = si_q;
    sj_d        = sj_q;
    key_len_d   = key_len_q;
    k_clr       = 1'b0;
    k_en        = 1'b0;
    err_d       = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_wren_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          if (key_len_ok) begin
            i_d       = '0;
            j_d       = '0;
            k_clr     = 1'b1;
            key_len_d = key_len;
            state_d   = init_en ? ST_INIT_WR : ST_RD_SI;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_INIT_WR: begin
        i_d = i_q + DEPTH_LOG2'(1);
        if (i_q == IDX_MAX) begin
          state_d = ST_RD_SI;
        end
      end
      ST_RD_SI: state_d = ST_CAP_SI;
      ST_CAP_SI: begin
        si_d    = mem_rdata;
        j_d     = j_q + mem_rdata + key_byte_n;
        state_d = ST_RD_SJ;
      end
      ST_RD_SJ: state_d = ST_CAP_SJ;
      ST_CAP_SJ: begin
        sj_d    = mem_rdata;
        state_d = ST_WR_SJ;
      end
      ST_WR_SJ: state_d = ST_WR_SI;
      ST_WR_SI: state_d = ST_NEXT;
      ST_NEXT: begin
        if (i_q == IDX_MAX) begin
          state_d = ST_DONE;
        end else begin
          i_d     = i_q + DEPTH_LOG2'(1);
          k_en    = 1'b1;
          state_d = ST_RD_SI;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_INIT_WR: begin
        mem_addr_d  = i_d;
        mem_wdata_d = i_d;
        mem_wren_d  = 1'b1;
      end
      ST_RD_SI: mem_addr_d = i_d;
      ST_RD_SJ: mem_addr_d = j_d;
      ST_WR_SJ: begin
        mem_addr_d  = j_d;
        mem_wdata_d = si_d;
        mem_wren_d  = 1'b1;
      end
      ST_WR_SI: begin
        mem_addr_d  = i_d;
        mem_wdata_d = sj_d;
        mem_wren_d  = 1'b1;
      end
      default: begin
        mem_addr_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      key_len_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      key_len_q   <= key_len_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Self-checking bench for rc4_ksa_engine with a behavioural S RAM and RC4 KSA model.
module tb_rc4_ksa_engine;

  logic         clk;
  logic         reset;
  logic         start;
  logic         init_en;
  logic [4:0]   key_len;
  logic [127:0] key;
  logic [7:0]   mem_rdata;
  logic [7:0]   mem_addr;
  logic [7:0]   mem_wdata;
  logic         mem_wren;
  logic         busy;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ram   [256];
  logic [7:0] exp_s [256];
  int         exp_j [$];
  logic [7:0] wr_addr [$];
  logic [7:0] wr_data [$];

  rc4_ksa_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .init_en   (init_en),
    .key_len   (key_len),
    .key       (key),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wren  (mem_wren),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM: read data valid the cycle after the address.
  always @(posedge clk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Write log sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wren) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  // Reference RC4 KSA on exp_s; records j per iteration.
  task automatic ksa_model(input int len, input logic [127:0] kv);
    int j;
    logic [7:0] t;
    logic [7:0] kb;
    exp_j.delete();
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = kv[8*(i % len) +: 8];
      j = (j + int'(exp_s[i]) + int'(kb)) % 256;
      exp_j.push_back(j);
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  // Full run: start, optional busy-time poke, wait for done, check latency, writes and S.
  task automatic run_ksa(input logic ie, input logic [4:0] len, input logic [127:0] kv,
                         input int poke, input string name);
    int n;
    int bad;
    int first_bad;
    bit seen;
    int exp_lat;
    int exp_wr;
    @(negedge clk);
    wr_addr.delete();
    wr_data.delete();
    init_en = ie;
    key_len = len;
    key     = kv;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
    end
    n = 0;
    seen = 0;
    while (!seen && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      if (poke != 0 && n == poke) begin
        start   = 1'b1;
        key_len = 5'd5;
      end else if (poke != 0 && n == poke + 1) begin
        start   = 1'b0;
        key_len = len;
      end
      if (done === 1'b1) seen = 1;
    end
    exp_lat = ie ? 2048 : 1792;
    exp_wr  = ie ? 768 : 512;
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s done_timeout: done never rose within %0d edges", name, n);
    end else if (n != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges required %0d", name, n, exp_lat);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy_at_done: got %b required 0", name, busy);
    end
    n_checks++;
    if (wr_addr.size() != exp_wr) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d required %0d", name, wr_addr.size(), exp_wr);
    end
    if (ie) begin
      for (int a = 0; a < 256; a++) exp_s[a] = 8'(a);
    end
    ksa_model(int'(len), kv);
    bad = 0;
    first_bad = -1;
    for (int a = 0; a < 256; a++) begin
      if (ram[a] !== exp_s[a]) begin
        bad++;
        if (first_bad < 0) first_bad = a;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s s_array: %0d entries differ, first S[%0d]=%0d required %0d",
               name, bad, first_bad, ram[first_bad], exp_s[first_bad]);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start   = 1'b0;
    init_en = 1'b0;
    key_len = 5'd0;
    key     = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({mem_addr, mem_wdata, mem_wren, busy, done, err} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_values: addr=%0d wdata=%0d wren=%b busy=%b done=%b err=%b required all 0",
               mem_addr, mem_wdata, mem_wren, busy, done, err);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_single_byte_key();
    logic [127:0] kv;
    kv = {$urandom, $urandom, $urandom, $urandom};
    kv[7:0] = 8'h00;
    run_ksa(1'b1, 5'd1, kv, 0, "key1");
    n_checks++;
    if (wr_addr[256] !== 8'd0 || wr_data[256] !== 8'd0 || wr_addr[258] !== 8'd1 || wr_data[258] !== 8'd1) begin
      n_fail++;
      $display("FAIL key1_early_writes: S[%0d]<=%0d, S[%0d]<=%0d required S[0]<=0, S[1]<=1",
               wr_addr[256], wr_data[256], wr_addr[258], wr_data[258]);
    end
    n_checks++;
    if (wr_addr[260] !== 8'd3 || wr_data[260] !== 8'd2 || wr_addr[261] !== 8'd2 || wr_data[261] !== 8'd3) begin
      n_fail++;
      $display("FAIL key1_first_swap: S[%0d]<=%0d, S[%0d]<=%0d required S[3]<=2, S[2]<=3",
               wr_addr[260], wr_data[260], wr_addr[261], wr_data[261]);
    end
  endtask

  task automatic test_three_byte_key();
    logic [127:0] kv;
    kv = {104'h0, 8'hFF, 8'h03, 8'h00};
    run_ksa(1'b1, 5'd3, kv, 0, "key3");
    for (int t = 0; t < 4; t++) begin
      n_checks++;
      if (int'(wr_addr[256 + 2*t]) != exp_j[t]) begin
        n_fail++;
        $display("FAIL key3_j_iter%0d: write address %0d required %0d", t, wr_addr[256 + 2*t], exp_j[t]);
      end
    end
  endtask

  task automatic test_illegal_key_len();
    logic [4:0] bad_len [2];
    logic prev_done;
    bad_len[0] = 5'd0;
    bad_len[1] = 5'd17;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      wr_addr.delete();
      wr_data.delete();
      prev_done = done;
      init_en = 1'b1;
      key_len = bad_len[t];
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_checks++;
      if (err !== 1'b1 || busy !== 1'b0 || done !== prev_done) begin
        n_fail++;
        $display("FAIL illegal_len%0d_pulse: err=%b busy=%b done=%b required err=1 busy=0 done=%b",
                 bad_len[t], err, busy, done, prev_done);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL illegal_len%0d_after: err=%b busy=%b required 0 0", bad_len[t], err, busy);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (wr_addr.size() != 0) begin
        n_fail++;
        $display("FAIL illegal_len%0d_writes: got %0d writes required 0", bad_len[t], wr_addr.size());
      end
    end
  endtask

  task automatic test_no_init_rerun();
    logic [127:0] kv;
    kv = {$urandom, $urandom, $urandom, $urandom};
    run_ksa(1'b0, 5'($urandom_range(16, 1)), kv, 0, "noinit");
  endtask

  task automatic test_random_keys();
    logic [127:0] kv;
    for (int r = 0; r < 3; r++) begin
      kv = {$urandom, $urandom, $urandom, $urandom};
      run_ksa(r != 2, 5'($urandom_range(16, 1)), kv, 0, "random");
    end
    kv = {$urandom, $urandom, $urandom, $urandom};
    run_ksa(1'b1, 5'd16, kv, 0, "maxlen");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    init_en = 1'b1;
    key_len = 5'd7;
    key     = {$urandom, $urandom, $urandom, $urandom};
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (499) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_busy: got %b required 1", busy);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if ({mem_addr, mem_wdata, mem_wren, busy, done, err} !== 20'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: addr=%0d wdata=%0d wren=%b busy=%b done=%b err=%b required all 0",
               mem_addr, mem_wdata, mem_wren, busy, done, err);
    end
    @(negedge clk);
    reset = 1'b0;
    run_ksa(1'b1, 5'($urandom_range(16, 1)), {$urandom, $urandom, $urandom, $urandom}, 0, "post_reset");
  endtask

  task automatic test_back_to_back();
    run_ksa(1'b1, 5'd4, {$urandom, $urandom, $urandom, $urandom}, 100, "start_while_busy");
    run_ksa(1'b1, 5'd9, {$urandom, $urandom, $urandom, $urandom}, 0, "restart_in_done");
  endtask

  initial begin
    test_reset();
    test_single_byte_key();
    test_three_byte_key();
    test_illegal_key_len();
    test_no_init_rerun();
    test_random_keys();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
